// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: prescaled pixel tick, x/y counters and
// registered sync / visible-area decodes aligned with the counters.
module vga_sync_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       clr,
    output logic       pix_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]    HS_BEG   = 10'(H_VIS + H_FP);
    localparam logic [9:0]    HS_END   = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0]    VS_BEG   = 10'(V_VIS + V_FP);
    localparam logic [9:0]    VS_END   = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [9:0]    H_VIS_L  = 10'(H_VIS);
    localparam logic [9:0]    V_VIS_L  = 10'(V_VIS);

    logic [PW-1:0] pre_q, pre_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic          tick_q, tick_d;
    logic          fs_q, fs_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          vid_q, vid_d;
    logic          x_wrap, y_wrap;

    always_comb begin
        tick_d = (pre_q == PRE_LAST);
        pre_d  = tick_d ? '0 : pre_q + PW'(1);
        x_wrap = (x_q == H_LAST);
        y_wrap = (y_q == V_LAST);
        x_d    = x_q;
        y_d    = y_q;
        if (tick_d) begin
            x_d = x_wrap ? 10'd0 : x_q + 10'd1;
            if (x_wrap) begin
                y_d = y_wrap ? 10'd0 : y_q + 10'd1;
            end
        end
        fs_d = tick_d && x_wrap && y_wrap;
        // Decode the next counter values so the flags line up with x/y.
        hs_d  = (x_d >= HS_BEG && x_d <= HS_END) ? SYNC_POL : ~SYNC_POL;
        vs_d  = (y_d >= VS_BEG && y_d <= VS_END) ? SYNC_POL : ~SYNC_POL;
        vid_d = (x_d < H_VIS_L) && (y_d < V_VIS_L);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pre_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            tick_q <= 1'b0;
            fs_q   <= 1'b0;
            hs_q   <= ~SYNC_POL;
            vs_q   <= ~SYNC_POL;
            vid_q  <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            x_q    <= x_d;
            y_q    <= y_d;
            tick_q <= tick_d;
            fs_q   <= fs_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            vid_q  <= vid_d;
        end
    end

    assign pix_tick    = tick_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign video_on    = vid_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three configurations checked every cycle
// against a closed-form timeline of clk edges since reset release.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr_a, clr_b, clr_c;

    logic       tick_a, hs_a, vs_a, vid_a, fs_a;
    logic [9:0] x_a, y_a;
    logic       tick_b, hs_b, vs_b, vid_b, fs_b;
    logic [9:0] x_b, y_b;
    logic       tick_c, hs_c, vs_c, vid_c, fs_c;
    logic [9:0] x_c, y_c;

    int n_chk  = 0;
    int n_pass = 0;
    int fs_cnt = 0;

    vga_sync_gen u_a (
        .clk(clk), .clr(clr_a), .pix_tick(tick_a),
        .hsync(hs_a), .vsync(vs_a), .video_on(vid_a),
        .x(x_a), .y(y_a), .frame_start(fs_a)
    );

    vga_sync_gen #(
        .CLK_DIV(2), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
    ) u_b (
        .clk(clk), .clr(clr_b), .pix_tick(tick_b),
        .hsync(hs_b), .vsync(vs_b), .video_on(vid_b),
        .x(x_b), .y(y_b), .frame_start(fs_b)
    );

    vga_sync_gen #(
        .CLK_DIV(1), .SYNC_POL(1'b1)
    ) u_c (
        .clk(clk), .clr(clr_c), .pix_tick(tick_c),
        .hsync(hs_c), .vsync(vs_c), .video_on(vid_c),
        .x(x_c), .y(y_c), .frame_start(fs_c)
    );

    always @(negedge clk) if (fs_b) fs_cnt++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [31:0] obs(input int id);
        case (id)
            0: return {7'd0, tick_a, hs_a, vs_a, vid_a, fs_a, x_a, y_a};
            1: return {7'd0, tick_b, hs_b, vs_b, vid_b, fs_b, x_b, y_b};
            default:
               return {7'd0, tick_c, hs_c, vs_c, vid_c, fs_c, x_c, y_c};
        endcase
    endfunction

    // Expected outputs k rising edges after reset release.
    function automatic logic [31:0] model(input int id, input int k);
        int div, hv, hf, hsw, hb, vv, vf, vsw, vb;
        int ht, vt, n, xi, yi;
        logic pol, tk, hs, vs, vid, fs;
        div = 2; hv = 640; hf = 16; hsw = 96; hb = 48;
        vv = 480; vf = 10; vsw = 2; vb = 33; pol = 1'b0;
        if (id == 1) begin
            hv = 8; hf = 2; hsw = 3; hb = 2;
            vv = 4; vf = 1; vsw = 2; vb = 1;
        end else if (id == 2) begin
            div = 1; pol = 1'b1;
        end
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        if (k == 0)
            return {7'd0, 1'b0, ~pol, ~pol, 1'b0, 1'b0, 20'd0};
        n   = k / div;
        tk  = (k % div) == 0;
        xi  = n % ht;
        yi  = (n / ht) % vt;
        hs  = (xi >= hv + hf && xi < hv + hf + hsw) ? pol : ~pol;
        vs  = (yi >= vv + vf && yi < vv + vf + vsw) ? pol : ~pol;
        vid = (xi < hv) && (yi < vv);
        fs  = tk && n > 0 && xi == 0 && yi == 0;
        return {7'd0, tk, hs, vs, vid, fs, 10'(xi), 10'(yi)};
    endfunction

    function automatic string nm(input int id);
        case (id)
            0: return "A";
            1: return "B";
            default: return "C";
        endcase
    endfunction

    task automatic set_clr(input int id, input logic v);
        case (id)
            0: clr_a = v;
            1: clr_b = v;
            default: clr_c = v;
        endcase
    endtask

    task automatic rel(input int id);
        @(negedge clk);
        set_clr(id, 1'b1);
        #1;
        chk($sformatf("%s release k=0", nm(id)), obs(id), model(id, 0));
    endtask

    task automatic run(input int id, input int k0, input int n);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            chk($sformatf("%s k=%0d", nm(id), k0 + i),
                obs(id), model(id, k0 + i));
        end
    endtask

    initial begin
        clr_a = 1'b0;
        clr_b = 1'b0;
        clr_c = 1'b0;
        repeat (3) @(negedge clk);
        for (int id = 0; id < 3; id++)
            chk($sformatf("%s reset", nm(id)), obs(id), model(id, 0));

        // Default timing: two full lines plus a little.
        rel(0);
        run(0, 0, 3300);

        // Small geometry: two frames, then async clear mid-sync.
        rel(1);
        fs_cnt = 0;
        run(1, 0, 485);
        chk("B frame_start count", 32'(fs_cnt), 32'd2);
        run(1, 485, 167);
        chk("B x,y before clr", {12'd0, x_b, y_b}, {12'd0, 10'd11, 10'd5});
        chk("B syncs before clr", {30'd0, hs_b, vs_b}, 32'd0);
        #1;
        clr_b = 1'b0;
        #1;
        chk("B async clr", obs(1), model(1, 0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("B clr held", obs(1), model(1, 0));
        end
        rel(1);
        fs_cnt = 0;
        run(1, 0, 485);
        chk("B frame_start count 2", 32'(fs_cnt), 32'd2);

        // Divide-by-one, active-high syncs.
        rel(2);
        run(2, 0, 1700);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
